// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit seven-segment scan controller:
// FSM state encoding, digit-count constants and a wrap-detection helper.
package seg7_pkg;

  // Number of multiplexed digits and the width of a digit index.
  localparam int NUM_DIGITS = 8;
  localparam int SCAN_W     = 3;

  // Scan FSM states. IDLE and BLANK keep all anodes dark; SHOW drives one digit.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // An advance wraps (closes a frame) when the new index is not above the old one.
  // A lone enabled digit advances onto itself, which also counts as a wrap.
  function automatic logic seg7_wraps(input logic [SCAN_W-1:0] new_idx,
                                      input logic [SCAN_W-1:0] old_idx);
    return (new_idx <= old_idx);
  endfunction

endpackage

// File: rtl/seg7_next_digit.sv
// Wrap-around priority search: returns the first set mask bit strictly above
// 'cur', continuing from bit 0 after bit 7 and finally reaching 'cur' itself.
// With cur = 7 the result is the lowest set bit of the mask.
module seg7_next_digit
  import seg7_pkg::*;
(
  input  logic [SCAN_W-1:0]     cur,
  input  logic [NUM_DIGITS-1:0] mask,
  output logic [SCAN_W-1:0]     nxt,
  output logic                  found,
  output logic                  wrap
);

  logic [2*NUM_DIGITS-1:0] dbl_s;
  logic [3:0]              shift_s;
  logic [NUM_DIGITS-1:0]   rot_s;
  logic [SCAN_W-1:0]       off_s;

  // Rotate the mask so bit 0 is the digit just above 'cur', then take the lowest set bit.
  always_comb begin
    dbl_s   = {mask, mask};
    shift_s = {1'b0, cur} + 4'd1;
    rot_s   = NUM_DIGITS'(dbl_s >> shift_s);
    found   = 1'b0;
    off_s   = 3'd0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        found = 1'b1;
        off_s = 3'(k);
      end else begin
        found = found;
      end
    end
    if (found) begin
      nxt  = cur + 3'd1 + off_s;
      wrap = seg7_wraps(nxt, cur);
    end else begin
      nxt  = cur;
      wrap = 1'b0;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller. Cycles through the enabled
// digits with a blanking gap between each, and double-buffers display data
// so a new load only becomes visible at a frame boundary (no tearing).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DWELL     = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  digit_en,
  input  logic        load,
  input  logic [31:0] hexs_in,
  input  logic [7:0]  point_in,
  input  logic [7:0]  les_in,
  output logic [2:0]  scan,
  output logic [31:0] hexs,
  output logic [7:0]  point,
  output logic [7:0]  les,
  output logic        blank,
  output logic        busy,
  output logic        load_ack,
  output logic        frame_start
);

  // One shared timer covers both the blanking gap and the dwell.
  localparam int TMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);

  // Scan sequencing state.
  state_t            state_r, state_nx_s;
  logic [TW-1:0]     timer_r, timer_nx_s;
  logic [SCAN_W-1:0] scan_r, scan_nx_s;
  logic              parked_r, parked_nx_s;
  logic              blank_r;
  logic              frame_start_r;
  logic              boundary_s;

  // Display data: committed copy plus pending buffer.
  logic [31:0]       hexs_r, pend_hexs_r;
  logic [7:0]        point_r, pend_point_r;
  logic [7:0]        les_r, pend_les_r;
  logic              busy_r, busy_nx_s;
  logic              load_ack_r;
  logic              commit_s;
  logic              take_s;

  // Next-digit search.
  logic [SCAN_W-1:0] search_cur_s;
  logic [SCAN_W-1:0] nd_s;
  logic              nd_found_s;
  logic              nd_wrap_s;

  // From IDLE the search starts above digit 7, yielding the lowest enabled digit.
  always_comb begin
    if (state_r == ST_IDLE) begin
      search_cur_s = 3'd7;
    end else begin
      search_cur_s = scan_r;
    end
  end

  seg7_next_digit u_next_digit (
    .cur   (search_cur_s),
    .mask  (digit_en),
    .nxt   (nd_s),
    .found (nd_found_s),
    .wrap  (nd_wrap_s)
  );

  // Next-state logic: phase timing, digit advance and frame-boundary detection.
  always_comb begin
    state_nx_s  = state_r;
    timer_nx_s  = timer_r;
    scan_nx_s   = scan_r;
    parked_nx_s = parked_r;
    boundary_s  = 1'b0;
    if (!en) begin
      // Disabling drops straight to dark; scan position and pending data survive.
      state_nx_s  = ST_IDLE;
      timer_nx_s  = {TW{1'b0}};
      parked_nx_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (nd_found_s) begin
            state_nx_s = ST_BLANK;
            timer_nx_s = {TW{1'b0}};
            scan_nx_s  = nd_s;
            boundary_s = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_BLANK: begin
          if (timer_r == BLANK_LAST) begin
            timer_nx_s = {TW{1'b0}};
            if (!parked_r) begin
              state_nx_s = ST_SHOW;
            end else if (nd_found_s) begin
              // Mask was empty at the last advance; resume from the parked index.
              state_nx_s  = ST_SHOW;
              parked_nx_s = 1'b0;
              scan_nx_s   = nd_s;
              boundary_s  = nd_wrap_s;
            end else begin
              // Still nothing enabled: re-arm another blanking period.
              state_nx_s = ST_BLANK;
            end
          end else begin
            timer_nx_s = timer_r + TW'(1'b1);
          end
        end
        ST_SHOW: begin
          if (timer_r == DWELL_LAST) begin
            // digit_en is only looked at here, so a dwell is never cut short.
            timer_nx_s = {TW{1'b0}};
            state_nx_s = ST_BLANK;
            if (nd_found_s) begin
              scan_nx_s  = nd_s;
              boundary_s = nd_wrap_s;
            end else begin
              parked_nx_s = 1'b1;
            end
          end else begin
            timer_nx_s = timer_r + TW'(1'b1);
          end
        end
        default: begin
          state_nx_s  = ST_IDLE;
          timer_nx_s  = {TW{1'b0}};
          parked_nx_s = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers; blank and frame_start are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      timer_r       <= {TW{1'b0}};
      scan_r        <= 3'd0;
      parked_r      <= 1'b0;
      blank_r       <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      timer_r       <= timer_nx_s;
      scan_r        <= scan_nx_s;
      parked_r      <= parked_nx_s;
      blank_r       <= (state_nx_s != ST_SHOW);
      frame_start_r <= boundary_s;
    end
  end

  // Load handshake: commit at a boundary, and a same-cycle load refills the buffer.
  always_comb begin
    commit_s = boundary_s & busy_r;
    take_s   = load & (~busy_r | commit_s);
    if (commit_s) begin
      busy_nx_s = load;
    end else begin
      busy_nx_s = busy_r | load;
    end
  end

  // Display data registers: pending capture and frame-aligned commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_hexs_r  <= 32'd0;
      pend_point_r <= 8'd0;
      pend_les_r   <= 8'd0;
      hexs_r       <= 32'd0;
      point_r      <= 8'd0;
      les_r        <= 8'd0;
      busy_r       <= 1'b0;
      load_ack_r   <= 1'b0;
    end else begin
      busy_r     <= busy_nx_s;
      load_ack_r <= commit_s;
      if (take_s) begin
        pend_hexs_r  <= hexs_in;
        pend_point_r <= point_in;
        pend_les_r   <= les_in;
      end
      if (commit_s) begin
        hexs_r  <= pend_hexs_r;
        point_r <= pend_point_r;
        les_r   <= pend_les_r;
      end
    end
  end

  assign scan        = scan_r;
  assign hexs        = hexs_r;
  assign point       = point_r;
  assign les         = les_r;
  assign blank       = blank_r;
  assign busy        = busy_r;
  assign load_ack    = load_ack_r;
  assign frame_start = frame_start_r;

endmodule
